// File: rtl/instr_fetch_aligner_pkg.sv
// Shared sizing constants and helpers for the instruction fetch aligner.
// Byte-granular quantities are in bytes, widths in bits.
package instr_fetch_aligner_pkg;

   localparam int IFA_DEPTH   = 16;
   localparam int IFA_PTR_W   = 4;
   localparam int INSTR_BYTES = 5;
   localparam int FETCH_BYTES = 4;
   localparam int INSTR_W     = 40;
   localparam int FETCH_W     = 32;

   // Decoder may retire 1..5 bytes; anything else is treated as no retire.
   function automatic logic valid_len(input logic [2:0] len);
      return (len != 3'd0) && (len <= 3'd5);
   endfunction

endpackage

// File: rtl/instr_fetch_aligner_byte_queue.sv
// Circular byte storage: 4-byte aligned write port and a 5-byte wrapped read port.
// Storage is deliberately not reset; the top masks bytes beyond the valid count.
module byte_queue
   import instr_fetch_aligner_pkg::*;
#(
   parameter int DEPTH = IFA_DEPTH,
   parameter int PTR_W = IFA_PTR_W
) (
   input  logic               clk_i,
   input  logic               wr_en_i,
   input  logic [PTR_W-1:0]   wr_ptr_i,
   input  logic [FETCH_W-1:0] wr_data_i,
   input  logic [PTR_W-1:0]   rd_ptr_i,
   output logic [INSTR_W-1:0] rd_data_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int i = 0; i < FETCH_BYTES; i++) begin
            mem_q[wr_ptr_i + PTR_W'(i)] <= wr_data_i[8*i +: 8];
         end
      end
   end

   // Oldest byte lands in the most significant lane of the window.
   for (genvar k = 0; k < INSTR_BYTES; k++) begin : g_rd
      assign rd_data_o[INSTR_W-1-8*k -: 8] = mem_q[rd_ptr_i + PTR_W'(k)];
   end

endmodule

// File: rtl/instr_fetch_aligner.sv
// Fetch-word to instruction-register aligner: queues 32-bit fetch words as bytes and
// presents the oldest five as a 40-bit window the decoder retires 1..5 bytes at a time.
module instr_fetch_aligner
   import instr_fetch_aligner_pkg::*;
#(
   parameter int DEPTH = IFA_DEPTH,
   parameter int PTR_W = IFA_PTR_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               fetch_valid_i,
   input  logic [FETCH_W-1:0] fetch_data_i,
   output logic               fetch_ready_o,
   output logic [INSTR_W-1:0] ir_wdata_o,
   output logic               ir_we_o,
   output logic [2:0]         win_bytes_o,
   input  logic               consume_i,
   input  logic [2:0]         consume_len_i
);

   localparam logic [PTR_W:0] CNT_PUSH_MAX = (PTR_W+1)'(DEPTH - FETCH_BYTES);
   localparam logic [PTR_W:0] CNT_WIN      = (PTR_W+1)'(INSTR_BYTES);

   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               push, pop;
   logic [PTR_W:0]     push_amt, pop_amt;
   logic [INSTR_W-1:0] raw_win;

   assign fetch_ready_o = (count_q <= CNT_PUSH_MAX);
   assign ir_we_o       = (count_q >= CNT_WIN) & ~flush_i;
   assign win_bytes_o   = (count_q >= CNT_WIN) ? 3'd5 : count_q[2:0];

   assign push = fetch_valid_i & fetch_ready_o;
   assign pop  = consume_i & ir_we_o & valid_len(consume_len_i);

   // A word offered during a flush is dropped, so it must not touch storage either.
   byte_queue #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_byte_queue (
      .clk_i     (clk_i),
      .wr_en_i   (push & ~flush_i),
      .wr_ptr_i  (wr_ptr_q),
      .wr_data_i (fetch_data_i),
      .rd_ptr_i  (rd_ptr_q),
      .rd_data_o (raw_win)
   );

   always_comb begin
      ir_wdata_o = '0;
      for (int k = 0; k < INSTR_BYTES; k++) begin
         if (count_q > (PTR_W+1)'(k)) begin
            ir_wdata_o[INSTR_W-1-8*k -: 8] = raw_win[INSTR_W-1-8*k -: 8];
         end
      end
   end

   always_comb begin
      push_amt = push ? (PTR_W+1)'(FETCH_BYTES) : '0;
      pop_amt  = pop ? (PTR_W+1)'(consume_len_i) : '0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + push_amt - pop_amt;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(consume_len_i);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(FETCH_BYTES);
      end
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
